// File: rtl/param_stack_unit.sv
// ---------------------------------------------------------------------------
// param_stack_unit
//
// Parametrised operand stack for the stack-machine datapath. Executes one op
// per clock (push, pop, dup, swap, ALU-result replace, clear) and exposes the
// top two entries combinationally from registered state. Overflow and
// underflow are detected on the pre-edge count. An illegal op leaves storage
// and count untouched, suppresses op_ok and raises a sticky error flag.
//
// Parameters:
//   WIDTH : data word width in bits (>=1)
//   DEPTH : number of stack entries (>=2)
//   CW    : width of count, derived from DEPTH
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   op_valid  : execute op on this edge when high
//   op        : 000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP,
//               101 REPLACE2, 110 REPLACE1, 111 CLEAR
//   push_data : value written by PUSH / REPLACE1 / REPLACE2
//   tos, nos  : top and second entries, zero when not present
//   count     : number of valid entries, 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   op_ok     : one-cycle pulse, previous-edge op was valid and legal
//   err_ovf   : sticky overflow flag
//   err_udf   : sticky underflow flag
// ---------------------------------------------------------------------------
module param_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             op_ok,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_PUSH     = 3'b001,
    OP_POP      = 3'b010,
    OP_DUP      = 3'b011,
    OP_SWAP     = 3'b100,
    OP_REPLACE2 = 3'b101,
    OP_REPLACE1 = 3'b110,
    OP_CLEAR    = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    idx_c;
  logic [AW-1:0]    idx_c1;
  logic [AW-1:0]    idx_c2;
  logic [WIDTH-1:0] top_raw;
  logic [WIDTH-1:0] sec_raw;
  logic             has_two;

  logic             legal;
  logic             set_ovf;
  logic             set_udf;
  logic             clr_err;
  logic [CW-1:0]    count_nxt;
  logic             wr0_en;
  logic [AW-1:0]    wr0_idx;
  logic [WIDTH-1:0] wr0_data;
  logic             wr1_en;
  logic [AW-1:0]    wr1_idx;
  logic [WIDTH-1:0] wr1_data;

  // Slot addresses relative to the current count. The c-1 and c-2 values
  // wrap when count is small, but they are only used when legality holds.
  always_comb begin
    idx_c   = AW'(count);
    idx_c1  = AW'(count - CW'(1));
    idx_c2  = AW'(count - CW'(2));
    top_raw = mem[idx_c1];
    sec_raw = mem[idx_c2];
    has_two = (count >= CW'(2));
  end

  // Status outputs. The storage array is never reset, so tos/nos are masked
  // by count to hide stale or uninitialised entries.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    tos   = empty   ? '0 : top_raw;
    nos   = has_two ? sec_raw : '0;
  end

  // Op decode: legality against the pre-edge count, next count and up to two
  // storage writes (SWAP is the only op that needs the second write port).
  // DUP on an empty stack checks underflow first so only err_udf is raised.
  always_comb begin
    legal     = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    clr_err   = 1'b0;
    count_nxt = count;
    wr0_en    = 1'b0;
    wr0_idx   = idx_c;
    wr0_data  = push_data;
    wr1_en    = 1'b0;
    wr1_idx   = idx_c2;
    wr1_data  = top_raw;
    if (op_valid) begin
      case (op_e'(op))
        OP_NOP: legal = 1'b1;
        OP_PUSH: begin
          if (!full) begin
            legal     = 1'b1;
            wr0_en    = 1'b1;
            wr0_idx   = idx_c;
            wr0_data  = push_data;
            count_nxt = count + CW'(1);
          end else begin
            set_ovf = 1'b1;
          end
        end
        OP_POP: begin
          if (!empty) begin
            legal     = 1'b1;
            count_nxt = count - CW'(1);
          end else begin
            set_udf = 1'b1;
          end
        end
        OP_DUP: begin
          if (empty) begin
            set_udf = 1'b1;
          end else if (full) begin
            set_ovf = 1'b1;
          end else begin
            legal     = 1'b1;
            wr0_en    = 1'b1;
            wr0_idx   = idx_c;
            wr0_data  = top_raw;
            count_nxt = count + CW'(1);
          end
        end
        OP_SWAP: begin
          if (has_two) begin
            legal    = 1'b1;
            wr0_en   = 1'b1;
            wr0_idx  = idx_c1;
            wr0_data = sec_raw;
            wr1_en   = 1'b1;
            wr1_idx  = idx_c2;
            wr1_data = top_raw;
          end else begin
            set_udf = 1'b1;
          end
        end
        OP_REPLACE2: begin
          if (has_two) begin
            legal     = 1'b1;
            wr0_en    = 1'b1;
            wr0_idx   = idx_c2;
            wr0_data  = push_data;
            count_nxt = count - CW'(1);
          end else begin
            set_udf = 1'b1;
          end
        end
        OP_REPLACE1: begin
          if (!empty) begin
            legal    = 1'b1;
            wr0_en   = 1'b1;
            wr0_idx  = idx_c1;
            wr0_data = push_data;
          end else begin
            set_udf = 1'b1;
          end
        end
        OP_CLEAR: begin
          legal     = 1'b1;
          clr_err   = 1'b1;
          count_nxt = '0;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Control state: count, op_ok pulse and sticky error flags. Reset wins over
  // any op presented on the same edge; CLEAR is the only other way to drop
  // the error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      op_ok   <= 1'b0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      count <= count_nxt;
      op_ok <= legal;
      if (clr_err) begin
        err_ovf <= 1'b0;
        err_udf <= 1'b0;
      end else begin
        if (set_ovf) err_ovf <= 1'b1;
        if (set_udf) err_udf <= 1'b1;
      end
    end
  end

  // Storage array, deliberately without reset. Writes are suppressed during
  // reset so an op coinciding with rst leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0_en) mem[wr0_idx] <= wr0_data;
      if (wr1_en) mem[wr1_idx] <= wr1_data;
    end
  end

endmodule

// File: tb/tb_param_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_param_stack_unit
//
// Directed self-checking bench for param_stack_unit (WIDTH=8, DEPTH=8).
// Each step drives one op, waits for the clock edge, and compares the
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_param_stack_unit;

  localparam logic [2:0] NOP      = 3'b000;
  localparam logic [2:0] PUSH     = 3'b001;
  localparam logic [2:0] POP      = 3'b010;
  localparam logic [2:0] DUP      = 3'b011;
  localparam logic [2:0] SWAP     = 3'b100;
  localparam logic [2:0] REPLACE2 = 3'b101;
  localparam logic [2:0] REPLACE1 = 3'b110;
  localparam logic [2:0] CLEAR    = 3'b111;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic [2:0] op;
  logic [7:0] push_data;
  logic [7:0] tos;
  logic [7:0] nos;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       op_ok;
  logic       err_ovf;
  logic       err_udf;

  int checks   = 0;
  int failures = 0;

  param_stack_unit #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op        (op),
    .push_data (push_data),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .op_ok     (op_ok),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op, take one rising edge, and let outputs settle before checks.
  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [7:0] d);
    op_valid  = v;
    op        = o;
    push_data = d;
    @(posedge clk);
    #2;
    op_valid  = 1'b0;
    op        = NOP;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Full snapshot of the observable state.
  task automatic checkState(input string tag, input int c, input int t, input int n,
                            input logic ok, input logic ovf, input logic udf);
    checkOutput({tag, ".count"}, 32'(count), 32'(c));
    checkOutput({tag, ".tos"}, 32'(tos), 32'(t));
    checkOutput({tag, ".nos"}, 32'(nos), 32'(n));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(c == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(c == 8));
    checkOutput({tag, ".op_ok"}, 32'(op_ok), 32'(ok));
    checkOutput({tag, ".err_ovf"}, 32'(err_ovf), 32'(ovf));
    checkOutput({tag, ".err_udf"}, 32'(err_udf), 32'(udf));
  endtask

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    op        = NOP;
    push_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkState("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic push and swap
    applyStimulus(1'b1, PUSH, 8'h11);
    checkState("push11", 1, 8'h11, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, PUSH, 8'h22);
    checkState("push22", 2, 8'h22, 8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, SWAP, 8'h00);
    checkState("swap", 2, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, PUSH, 8'h55);
    checkState("idle_invalid", 2, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP, 8'h55);
    checkState("nop_valid", 2, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0);

    // DUP, then SWAP with a single entry underflows
    applyStimulus(1'b1, CLEAR, 8'h00);
    checkState("clear_a", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, PUSH, 8'h01);
    applyStimulus(1'b1, DUP, 8'hEE);
    checkState("dup", 2, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, POP, 8'h00);
    checkState("pop", 1, 8'h01, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, SWAP, 8'h00);
    checkState("swap_udf", 1, 8'h01, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, REPLACE2, 8'h77);
    checkState("rep2_udf", 1, 8'h01, 0, 1'b0, 1'b0, 1'b1);

    // POP from empty, then a legal push with the error still sticky
    applyStimulus(1'b1, CLEAR, 8'h00);
    checkState("clear_b", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, POP, 8'h00);
    checkState("pop_empty", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DUP, 8'h00);
    checkState("dup_empty", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, PUSH, 8'h05);
    checkState("push5", 1, 8'h05, 0, 1'b1, 1'b0, 1'b1);

    // ALU result replace
    applyStimulus(1'b1, CLEAR, 8'h00);
    applyStimulus(1'b1, PUSH, 8'h03);
    applyStimulus(1'b1, PUSH, 8'h04);
    checkState("stack34", 2, 8'h04, 8'h03, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, REPLACE2, 8'h07);
    checkState("rep2", 1, 8'h07, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, REPLACE1, 8'h09);
    checkState("rep1", 1, 8'h09, 0, 1'b1, 1'b0, 1'b0);

    // Fill to DEPTH, then overflow on PUSH and DUP
    applyStimulus(1'b1, CLEAR, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, PUSH, 8'(i));
    end
    checkState("full", 8, 8'h08, 8'h07, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, PUSH, 8'h99);
    checkState("push_ovf", 8, 8'h08, 8'h07, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, DUP, 8'h00);
    checkState("dup_ovf", 8, 8'h08, 8'h07, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, POP, 8'h00);
    checkState("pop_after_ovf", 7, 8'h07, 8'h06, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, POP, 8'h00);
    checkState("count5_pre", 6, 8'h06, 8'h05, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, POP, 8'h00);
    checkState("count5", 5, 8'h05, 8'h04, 1'b1, 1'b1, 1'b0);

    // CLEAR drops errors; reset beats a coincident PUSH
    applyStimulus(1'b1, CLEAR, 8'h00);
    checkState("clear_err", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, PUSH, 8'h33);
    checkState("push33", 1, 8'h33, 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, PUSH, 8'h44);
    rst = 1'b0;
    checkState("rst_push", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
